uart_tx_scheduler: RTL and testbench

//   Shares one serial TX line and one external baud tick generator between two byte requesters.

---
 rtl/uart_tx_scheduler.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Shares one serial TX line and one external baud tick generator
//            between two valid/ready byte requesters. A round-robin arbiter
//            picks the requester, and the accepted byte is sent as an 8N1/8N2
//            style frame (start, DATA_BITS LSB first, STOP_BITS stop bits).
//            The tick generator is enabled through baud_en only while a frame
//            is in flight, so it re-phases at the start of every frame.
// Ports    : clk        system clock, all logic on posedge
//            rst_n      asynchronous active-low reset
//            req_valid  per-requester byte valid (bit i = requester i)
//            req_data0  byte from requester 0
//            req_data1  byte from requester 1
//            req_ready  per-requester accept (combinational, IDLE only)
//            baud_en    registered enable to the baud tick generator
//            baud_tick  one-cycle pulse per bit period
//            txd        serial output, idle high (registered)
//            busy       frame in progress (registered)
//            grant_id   requester owning the current/last frame
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  input  logic [DATA_BITS-1:0] req_data0,
  input  logic [DATA_BITS-1:0] req_data1,
  output logic [1:0]           req_ready,
  output logic                 baud_en,
  input  logic                 baud_tick,
  output logic                 txd,
  output logic                 busy,
  output logic                 grant_id
);

  localparam int                 CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e                state_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  stop_cnt_q;
  logic                  txd_q;
  logic                  baud_en_q;
  logic                  busy_q;
  logic                  grant_q;
  logic                  last_grant_q;

  logic                  win_id;
  logic [DATA_BITS-1:0]  win_data;

  // Arbiter: a lone valid wins outright; on contention the requester that
  // did not own the previous frame wins. Ready is only offered in IDLE and
  // only to the winner, so at most one transfer can happen per cycle.
  always_comb begin
    win_id = req_valid[1];
    if (req_valid == 2'b11) begin
      win_id = ~last_grant_q;
    end
    win_data  = win_id ? req_data1 : req_data0;
    req_ready = 2'b00;
    if (state_q == S_IDLE) begin
      req_ready = {win_id, ~win_id} & req_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      txd_q        <= 1'b1;
      baud_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;   // requester 0 wins the first contention
    end else begin
      case (state_q)
        // baud_tick is deliberately ignored here: the generator is held off
        // and any stray pulse must not shorten the coming start bit.
        S_IDLE: begin
          if (|req_ready) begin
            shift_q      <= win_data;
            grant_q      <= win_id;
            last_grant_q <= win_id;
            txd_q        <= 1'b0;
            baud_en_q    <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_START;
          end
        end

        S_START: begin
          if (baud_tick) begin
            bit_cnt_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= S_DATA;
          end
        end

        // txd is registered, so on each tick it is loaded with the bit that
        // the shift register will expose next (shift_q[1] before the shift).
        S_DATA: begin
          if (baud_tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
              stop_cnt_q <= 1'b0;
              txd_q      <= 1'b1;
              state_q    <= S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              txd_q     <= shift_q[1];
            end
          end
        end

        // Dropping baud_en on exit guarantees at least one IDLE cycle with the
        // generator disabled, so the next frame starts with a fresh bit phase.
        S_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              txd_q     <= 1'b1;
              baud_en_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end

        default: begin
          txd_q     <= 1'b1;
          baud_en_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign baud_en  = baud_en_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Self-checking bench for uart_tx_scheduler. One instance uses one
//            stop bit, a second uses two. Each instance is paired with a tick
//            generator that pulses every 16 clocks while baud_en is high and
//            re-phases while it is low. Expected frames, grants and ready
//            patterns come from a behavioural model of the arbitration and
//            frame format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // instance 1: STOP_BITS = 1
  logic [1:0] valid1;
  logic [7:0] d01, d11;
  logic [1:0] rdy1;
  logic       ben1, tick1, txd1, busy1, gid1, ftick1;
  int         cnt1;

  // instance 2: STOP_BITS = 2
  logic [1:0] valid2;
  logic [7:0] d02, d12;
  logic [1:0] rdy2;
  logic       ben2, tick2, txd2, busy2, gid2;
  int         cnt2;

  uart_tx_scheduler #(.DATA_BITS(8), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_data0(d01), .req_data1(d11),
    .req_ready(rdy1), .baud_en(ben1), .baud_tick(tick1), .txd(txd1), .busy(busy1),
    .grant_id(gid1)
  );

  uart_tx_scheduler #(.DATA_BITS(8), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid2), .req_data0(d02), .req_data1(d12),
    .req_ready(rdy2), .baud_en(ben2), .baud_tick(tick2), .txd(txd2), .busy(busy2),
    .grant_id(gid2)
  );

  // Tick generators: counter held at zero while disabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt1 <= 0;
    else if (!ben1)      cnt1 <= 0;
    else if (cnt1 == 15) cnt1 <= 0;
    else                 cnt1 <= cnt1 + 1;
  end
  assign tick1 = (ben1 && cnt1 == 15) || ftick1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt2 <= 0;
    else if (!ben2)      cnt2 <= 0;
    else if (cnt2 == 15) cnt2 <= 0;
    else                 cnt2 <= cnt2 + 1;
  end
  assign tick2 = ben2 && cnt2 == 15;

  int errors = 0;
  int checks = 0;
  int lg;                  // model: last granted requester on instance 1
  int rdy0_cnt = 0;        // cycles with req_ready[0] on instance 1
  int rdy_busy_cnt = 0;    // cycles with any ready while busy (instance 1)

  always @(negedge clk) begin
    if (rdy1[0] === 1'b1) rdy0_cnt <= rdy0_cnt + 1;
    if (busy1 === 1'b1 && rdy1 !== 2'b00) rdy_busy_cnt <= rdy_busy_cnt + 1;
  end

  logic cap  [0:255];
  logic capb [0:255];

  // Model of the line: bit period b of a frame is start(0), data LSB first,
  // then stop bits (1); each bit lasts 16 clocks.
  function automatic logic exp_level(input logic [7:0] d, input int k);
    int b;
    b = k / 16;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  function automatic int wave_errs(input logic [7:0] d, input int nt);
    int e = 0;
    for (int k = 0; k < nt * 16; k++) if (cap[k] !== exp_level(d, k)) e++;
    return e;
  endfunction

  function automatic int busy_errs(input int nt);
    int e = 0;
    for (int k = 0; k < nt * 16; k++) if (capb[k] !== 1'b1) e++;
    return e;
  endfunction

  // Records txd/busy at every falling edge from the first low sample on for
  // nt bit periods; returns at the falling edge just after the frame.
  task automatic capture(input int inst, input int nt, output bit tmo);
    int w = 0;
    tmo = 1'b0;
    while (((inst == 2) ? txd2 : txd1) !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      tmo = 1'b1;
      return;
    end
    for (int k = 0; k < nt * 16; k++) begin
      cap[k]  = (inst == 2) ? txd2 : txd1;
      capb[k] = (inst == 2) ? busy2 : busy1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (txd1 !== 1'b1)     begin errors++; $display("FAIL reset_txd: got %b want 1", txd1); end
    checks++; if (ben1 !== 1'b0)     begin errors++; $display("FAIL reset_baud_en: got %b want 0", ben1); end
    checks++; if (busy1 !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (gid1 !== 1'b0)     begin errors++; $display("FAIL reset_grant: got %b want 0", gid1); end
    checks++; if (rdy1 !== 2'b00)    begin errors++; $display("FAIL reset_ready: got %b want 00", rdy1); end
    checks++; if ({txd2, ben2} !== 2'b10) begin errors++; $display("FAIL reset_dut2: txd/baud_en got %b want 10", {txd2, ben2}); end
    rst_n = 1'b1;
    lg = 1;
    repeat (2) @(negedge clk);
    checks++; if ({txd1, busy1, ben1} !== 3'b100) begin errors++; $display("FAIL idle_after_reset: txd/busy/baud_en got %b want 100", {txd1, busy1, ben1}); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    bit tmo;
    int e;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      d01 = d; valid1 = 2'b01;
      #1;
      checks++; if (rdy1 !== 2'b01) begin errors++; $display("FAIL single_ready[%0d]: got %b want 01", i, rdy1); end
      @(posedge clk); @(negedge clk);
      valid1 = 2'b00; d01 = 8'($urandom);
      lg = 0;
      checks++; if (gid1 !== 1'b0) begin errors++; $display("FAIL single_grant[%0d]: got %b want 0", i, gid1); end
      capture(1, 10, tmo);
      checks++;
      if (tmo) begin errors++; $display("FAIL single_start[%0d]: txd never fell", i); end
      else begin
        e = wave_errs(d, 10);
        if (e !== 0) begin errors++; $display("FAIL single_wave[%0d]: data %h has %0d bad samples, want 0", i, d, e); end
        checks++; e = busy_errs(10);
        if (e !== 0) begin errors++; $display("FAIL single_busy[%0d]: %0d cycles busy low, want 0", i, e); end
        checks++; if ({busy1, ben1, txd1} !== 3'b001) begin errors++; $display("FAIL single_end[%0d]: busy/baud_en/txd got %b want 001", i, {busy1, ben1, txd1}); end
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] pend;
    logic [7:0] pd [2];
    int w, r, e;
    logic [1:0] er;
    bit tmo;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lg = 1;
    @(negedge clk);
    pend = 2'b11; pd[0] = 8'h11; pd[1] = 8'h22;
    for (int it = 0; it < 8; it++) begin
      if (it == 2) begin
        pend = 2'b11; pd[0] = 8'($urandom); pd[1] = 8'($urandom);
      end else if (pend == 2'b00) begin
        r = int'($urandom_range(1, 3));
        pend = 2'(r); pd[0] = 8'($urandom); pd[1] = 8'($urandom);
      end
      valid1 = pend; d01 = pd[0]; d11 = pd[1];
      #1;
      w  = (pend == 2'b11) ? 1 - lg : (pend[1] ? 1 : 0);
      er = (w == 1) ? 2'b10 : 2'b01;
      checks++; if (rdy1 !== er) begin errors++; $display("FAIL arb_ready[%0d]: got %b want %b", it, rdy1, er); end
      @(posedge clk); @(negedge clk);
      pend[w] = 1'b0; lg = w;
      valid1 = pend;
      checks++; if (gid1 !== 1'(w)) begin errors++; $display("FAIL arb_grant[%0d]: got %b want %0d", it, gid1, w); end
      capture(1, 10, tmo);
      checks++;
      if (tmo) begin errors++; $display("FAIL arb_start[%0d]: txd never fell", it); end
      else begin
        e = wave_errs(pd[w], 10);
        if (e !== 0) begin errors++; $display("FAIL arb_wave[%0d]: data %h has %0d bad samples, want 0", it, pd[w], e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3];
    int r0, e;
    bit tmo;
    r0 = rdy0_cnt;
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    valid1 = 2'b10; d11 = b[0];
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rdy1 !== 2'b10) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 10", i, rdy1); end
      @(posedge clk); @(negedge clk);
      if (i < 2) d11 = b[i+1]; else valid1 = 2'b00;
      checks++; if (gid1 !== 1'b1) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want 1", i, gid1); end
      capture(1, 10, tmo);
      checks++;
      if (tmo) begin errors++; $display("FAIL b2b_start[%0d]: txd never fell", i); end
      else begin
        e = wave_errs(b[i], 10);
        if (e !== 0) begin errors++; $display("FAIL b2b_wave[%0d]: data %h has %0d bad samples, want 0", i, b[i], e); end
        checks++; if (ben1 !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d]: baud_en got %b want 0 between frames", i, ben1); end
      end
    end
    checks++; if (rdy0_cnt !== r0) begin errors++; $display("FAIL b2b_ready0: req_ready[0] seen %0d cycles, want 0", rdy0_cnt - r0); end
    checks++; if (rdy_busy_cnt !== 0) begin errors++; $display("FAIL ready_while_busy: %0d cycles, want 0", rdy_busy_cnt); end
  endtask

  task automatic test_stop2();
    logic [7:0] d;
    bit tmo;
    int e;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 8'hFF : 8'($urandom);
      d12 = d; valid2 = 2'b10;
      #1;
      checks++; if (rdy2 !== 2'b10) begin errors++; $display("FAIL stop2_ready[%0d]: got %b want 10", i, rdy2); end
      @(posedge clk); @(negedge clk);
      valid2 = 2'b00;
      capture(2, 11, tmo);
      checks++;
      if (tmo) begin errors++; $display("FAIL stop2_start[%0d]: txd never fell", i); end
      else begin
        e = wave_errs(d, 11);
        if (e !== 0) begin errors++; $display("FAIL stop2_wave[%0d]: data %h has %0d bad samples, want 0", i, d, e); end
        checks++; e = busy_errs(11);
        if (e !== 0) begin errors++; $display("FAIL stop2_busy[%0d]: %0d cycles busy low, want 0", i, e); end
        checks++; if ({busy2, ben2} !== 2'b00) begin errors++; $display("FAIL stop2_end[%0d]: busy/baud_en got %b want 00", i, {busy2, ben2}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bit tmo;
    int e;
    d = 8'($urandom);
    d01 = d; valid1 = 2'b01;
    @(posedge clk); @(negedge clk);
    valid1 = 2'b00;
    repeat (72) @(negedge clk);   // middle of data bit 3
    checks++; if ({txd1, ben1} !== {d[3], 1'b1}) begin errors++; $display("FAIL mid_bit3: txd/baud_en got %b want %b", {txd1, ben1}, {d[3], 1'b1}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({txd1, ben1, busy1} !== 3'b100) begin errors++; $display("FAIL mid_reset: txd/baud_en/busy got %b want 100", {txd1, ben1, busy1}); end
    @(negedge clk);
    rst_n = 1'b1;
    lg = 1;
    @(negedge clk);
    d = 8'($urandom);
    d11 = d; valid1 = 2'b10;
    #1;
    checks++; if (rdy1 !== 2'b10) begin errors++; $display("FAIL mid_after_ready: got %b want 10", rdy1); end
    @(posedge clk); @(negedge clk);
    valid1 = 2'b00;
    capture(1, 10, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL mid_after_start: txd never fell"); end
    else begin
      e = wave_errs(d, 10);
      if (e !== 0) begin errors++; $display("FAIL mid_after_wave: data %h has %0d bad samples, want 0", d, e); end
    end
  endtask

  task automatic test_idle_ticks();
    logic [7:0] d;
    bit tmo;
    int bad = 0, e, z;
    for (int i = 0; i < 5; i++) begin
      ftick1 = 1'b1;
      @(negedge clk);
      ftick1 = 1'b0;
      repeat (2) begin
        if ({txd1, busy1, ben1} !== 3'b100) bad++;
        @(negedge clk);
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_ticks: %0d samples left idle, want 0", bad); end
    d = 8'($urandom) | 8'h01;
    d01 = d; valid1 = 2'b01; ftick1 = 1'b1;
    #1;
    checks++; if (rdy1 !== 2'b01) begin errors++; $display("FAIL tick_valid_ready: got %b want 01", rdy1); end
    @(posedge clk); @(negedge clk);
    ftick1 = 1'b0; valid1 = 2'b00;
    capture(1, 10, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL tick_valid_start: txd never fell"); end
    else begin
      z = 0;
      while (z < 160 && cap[z] === 1'b0) z++;
      if (z !== 16) begin errors++; $display("FAIL tick_valid_startlen: start bit %0d clk, want 16", z); end
      checks++; e = wave_errs(d, 10);
      if (e !== 0) begin errors++; $display("FAIL tick_valid_wave: data %h has %0d bad samples, want 0", d, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid1 = 2'b00; d01 = 8'h00; d11 = 8'h00; ftick1 = 1'b0;
    valid2 = 2'b00; d02 = 8'h00; d12 = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_stop2();
    test_reset_mid();
    test_idle_ticks();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
